// File: rtl/otp_gen_if.sv
// otp_gen_if: cipher-core handshake and pad-RAM write port of the keystream generator.
// The generator is master on both: it launches cipher blocks and writes pad nibbles.
interface otp_gen_if #(
   parameter int ADDR_W = 10
);
   logic              ostart_cipher;
   logic [63:0]       oblock;
   logic              icipher_done;
   logic [63:0]       icipher_block;
   logic [ADDR_W-1:0] opad_addr;
   logic [3:0]        opad_wdata;
   logic              opad_we;

   modport master (
      output ostart_cipher, oblock, opad_addr, opad_wdata, opad_we,
      input  icipher_done, icipher_block
   );

   modport slave (
      input  ostart_cipher, oblock, opad_addr, opad_wdata, opad_we,
      output icipher_done, icipher_block
   );
endinterface

// File: rtl/otp_gen.sv
// otp_gen: counter-mode one-time-pad generator; fills one 512-byte sector of pad RAM per request.
// Define OTP_BYPASS_EN to skip the cipher core and write the raw counter stream as a debug pattern.
module otp_gen #(
   parameter int SECTOR_BLOCKS = 64,
   parameter int ADDR_W        = 10
) (
   input  logic        iclk,
   input  logic        irst_n,
   input  logic [63:0] iiv,
   input  logic        inew_otp,
   input  logic        igen_otp,
   output logic        ootp_ready,
   otp_gen_if.master   bus
);

   localparam int BLK_W = ADDR_W - 4;
   localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(SECTOR_BLOCKS - 1);
   localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
`ifdef OTP_BYPASS_EN
   localparam logic START_PULSE = 1'b0;
`else
   localparam logic START_PULSE = 1'b1;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state_r;
   logic [63:0]       counter_r;
   logic [BLK_W-1:0]  blk_idx_r;
   logic [3:0]        nib_r;
   logic [63:0]       shift_r;
   logic              ready_r;
   logic              start_r;
   logic [63:0]       oblock_r;
   logic [ADDR_W-1:0] pad_addr_r;
   logic [3:0]        pad_wdata_r;
   logic              pad_we_r;
   logic [63:0]       ctr_next_s;

   assign ctr_next_s = counter_r + 64'd1;

`ifdef OTP_BYPASS_EN
   logic unused_cipher_s;
   assign unused_cipher_s = ^{bus.icipher_done, bus.icipher_block};
`endif

   // Sector sequencer: START launches a block, WAIT catches the cipher result, WRITE unpacks 16 nibbles.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_r     <= IDLE;
         counter_r   <= 64'd0;
         blk_idx_r   <= '0;
         nib_r       <= 4'd0;
         shift_r     <= 64'd0;
         ready_r     <= 1'b0;
         start_r     <= 1'b0;
         oblock_r    <= 64'd0;
         pad_addr_r  <= '0;
         pad_wdata_r <= 4'd0;
         pad_we_r    <= 1'b0;
      end else if (inew_otp) begin
         state_r   <= IDLE;
         counter_r <= iiv;
         ready_r   <= 1'b0;
         pad_we_r  <= 1'b0;
         start_r   <= 1'b0;
         blk_idx_r <= '0;
         nib_r     <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               ready_r  <= 1'b0;
               pad_we_r <= 1'b0;
               if (igen_otp) begin
                  state_r   <= START;
                  blk_idx_r <= '0;
                  nib_r     <= 4'd0;
                  start_r   <= START_PULSE;
                  oblock_r  <= counter_r;
               end else begin
                  start_r <= 1'b0;
               end
            end
            START: begin
               start_r <= 1'b0;
`ifdef OTP_BYPASS_EN
               state_r     <= WRITE;
               nib_r       <= 4'd0;
               pad_we_r    <= 1'b1;
               pad_addr_r  <= {blk_idx_r, 4'd0};
               pad_wdata_r <= counter_r[63:60];
               shift_r     <= {counter_r[59:0], 4'd0};
`else
               state_r <= WAIT;
`endif
            end
            WAIT: begin
               start_r <= 1'b0;
               if (bus.icipher_done) begin
                  state_r     <= WRITE;
                  nib_r       <= 4'd0;
                  pad_we_r    <= 1'b1;
                  pad_addr_r  <= {blk_idx_r, 4'd0};
                  pad_wdata_r <= bus.icipher_block[63:60];
                  shift_r     <= {bus.icipher_block[59:0], 4'd0};
               end else begin
                  state_r <= WAIT;
               end
            end
            WRITE: begin
               if (nib_r == 4'd15) begin
                  pad_we_r  <= 1'b0;
                  nib_r     <= 4'd0;
                  counter_r <= ctr_next_s;
                  if (blk_idx_r == LAST_BLK) begin
                     state_r <= DONE;
                     ready_r <= 1'b1;
                  end else begin
                     state_r   <= START;
                     blk_idx_r <= blk_idx_r + BLK_ONE;
                     start_r   <= START_PULSE;
                     oblock_r  <= ctr_next_s;
                  end
               end else begin
                  nib_r       <= nib_r + 4'd1;
                  pad_addr_r  <= {blk_idx_r, nib_r + 4'd1};
                  pad_wdata_r <= shift_r[63:60];
                  shift_r     <= {shift_r[59:0], 4'd0};
               end
            end
            DONE: begin
               // Ready holds only while the SD stage keeps asking; a dropped request releases it.
               if (igen_otp) begin
                  ready_r <= 1'b1;
               end else begin
                  ready_r <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r  <= IDLE;
               ready_r  <= 1'b0;
               start_r  <= 1'b0;
               pad_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign ootp_ready        = ready_r;
   assign bus.ostart_cipher = start_r;
   assign bus.oblock        = oblock_r;
   assign bus.opad_addr     = pad_addr_r;
   assign bus.opad_wdata    = pad_wdata_r;
   assign bus.opad_we       = pad_we_r;

endmodule
